// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: reset sequencer and lock supervisor for the video-clock PLL.
// Holds the PLL in reset, waits for lock, qualifies lock over a stability
// window, then releases the downstream domain reset.  It re-sequences on lock
// loss or timeout and latches FAULT after MAX_RETRY failed attempts.
// Optional feature: define PLL_LOCK_STATS_EN to add the 16-bit loss_cnt
// output, which counts RUN lock losses.
// Handshake note: there is no valid/ready handshake here.  restart is a
// single-cycle request that is always accepted, and ready is a level status
// output.
module pll_lock_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        locked_in,
   input  logic        restart,
   output logic        pll_rst,
   output logic        dom_rst_n,
   output logic        ready,
   output logic        fault,
   output logic [3:0]  retry_cnt,
`ifdef PLL_LOCK_STATS_EN
   output logic [15:0] loss_cnt,
`endif
   output logic [2:0]  dbg_state_o
);

   // The timer is wide enough for the largest window, and never narrower than 17 bits.
   function automatic int calc_tw();
      int m;
      int w;
      m = RST_CYCLES;
      if (LOCK_TIMEOUT > m) m = LOCK_TIMEOUT;
      if (STABLE_CYCLES > m) m = STABLE_CYCLES;
      w = $clog2(m + 1);
      return (w < 17) ? 17 : w;
   endfunction

   localparam int TW = calc_tw();

   localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
   localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      retry_q, retry_d;
   logic [3:0]      retry_inc;
   logic            lock_meta_q, lock_sync_q;
   logic            locked_s;
   logic            loss_evt;
   logic            pll_rst_q, pll_rst_d;
   logic            dom_rst_n_q, dom_rst_n_d;
   logic            ready_q, ready_d;
   logic            fault_q, fault_d;

   assign locked_s  = lock_sync_q;
   assign retry_inc = retry_q + 4'd1;

   // Two-flop synchronizer for the asynchronous PLL locked indication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= locked_in;
         lock_sync_q <= lock_meta_q;
      end
   end

   // State register together with the shared timer and the retry counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PLL_RST;
         timer_q <= '0;
         retry_q <= 4'd0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
      end
   end

   // Next-state logic. restart overrides every lock or timeout event in the same cycle.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + TW'(1);
      retry_d  = retry_q;
      loss_evt = 1'b0;
      unique case (state_q)
         ST_PLL_RST: begin
            if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABLE;
            end else if (timer_q == TIMEOUT_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
            end
         end
         ST_STABLE: begin
            if (!locked_s) state_d = ST_WAIT_LOCK;
            else if (timer_q == STABLE_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            timer_d = '0;
            if (!locked_s) begin
               state_d  = ST_PLL_RST;
               loss_evt = 1'b1;
            end
         end
         ST_FAULT: begin
            timer_d = '0;
         end
         default: begin
            state_d = ST_PLL_RST;
         end
      endcase
      // Every state entry starts the timer from zero.
      if (state_d != state_q) timer_d = '0;
      if (state_d == ST_RUN) retry_d = 4'd0;
      if (restart) begin
         state_d  = ST_PLL_RST;
         timer_d  = '0;
         retry_d  = 4'd0;
         loss_evt = 1'b0;
      end
   end

   // Output decode from the next state, so the registered outputs move with the state.
   always_comb begin
      pll_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
      dom_rst_n_d = (state_d == ST_RUN);
      ready_d     = (state_d == ST_RUN);
      fault_d     = (state_d == ST_FAULT);
   end

   // Output registers. Reset holds the PLL in reset and the domain in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pll_rst_q   <= 1'b1;
         dom_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         pll_rst_q   <= pll_rst_d;
         dom_rst_n_q <= dom_rst_n_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

`ifdef PLL_LOCK_STATS_EN
   logic [15:0] loss_q;

   // Saturating count of lock losses seen in RUN. restart clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= 16'd0;
      end else if (restart) begin
         loss_q <= 16'd0;
      end else if (loss_evt && (loss_q != 16'hFFFF)) begin
         loss_q <= loss_q + 16'd1;
      end
   end

   assign loss_cnt = loss_q;
`endif

   assign pll_rst     = pll_rst_q;
   assign dom_rst_n   = dom_rst_n_q;
   assign ready       = ready_q;
   assign fault       = fault_q;
   assign retry_cnt   = retry_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed and randomized sequence for pll_lock_ctrl.
// Expected timings are computed from the sequencing rules with plain
// arithmetic.  The clock edge count runs from the edge that starts a phase.
module tb_pll_lock_ctrl;

   localparam int R        = 4;
   localparam int T        = 32;
   localparam int S        = 8;
   localparam int M        = 2;
   localparam int SYNC_LAT = 2;
   // Edges from a locked_in rise to the ready rise, when the rise is seen in WAIT_LOCK.
   localparam int LOCK_TO_READY = SYNC_LAT + S + 1;
   // Edges per failed attempt: the reset window plus the lock-wait window.
   localparam int ATTEMPT = R + T;

   logic        clk;
   logic        rst_n;
   logic        locked_in;
   logic        restart;
   logic        pll_rst;
   logic        dom_rst_n;
   logic        ready;
   logic        fault;
   logic [3:0]  retry_cnt;
   logic [2:0]  dbg_state;
`ifdef PLL_LOCK_STATS_EN
   logic [15:0] loss_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   pll_lock_ctrl #(
      .RST_CYCLES   (R),
      .LOCK_TIMEOUT (T),
      .STABLE_CYCLES(S),
      .MAX_RETRY    (M)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .locked_in  (locked_in),
      .restart    (restart),
      .pll_rst    (pll_rst),
      .dom_rst_n  (dom_rst_n),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
`ifdef PLL_LOCK_STATS_EN
      .loss_cnt   (loss_cnt),
`endif
      .dbg_state_o(dbg_state)
   );

   // Clock and reset block.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check_bit({tag, "_pll_rst"}, pll_rst, 1'b1);
      check_bit({tag, "_dom_rst_n"}, dom_rst_n, 1'b0);
      check_bit({tag, "_ready"}, ready, 1'b0);
      check_bit({tag, "_fault"}, fault, 1'b0);
      check_val({tag, "_retry"}, 16'(retry_cnt), 16'd0);
   endtask

   // Assert reset between edges and check the values with no clock edge in between.
   task automatic assert_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outs(tag);
      locked_in = 1'b0;
      restart   = 1'b0;
   endtask

   // Release reset just after an edge, so the next edge is edge 1.
   task automatic release_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Bring up from a fresh reset release, with locked_in rising d edges later.
   task automatic clean_lock(input int d);
      for (int i = 1; i <= d; i++) begin
         tick();
         check_bit("cl_pll_rst", pll_rst, (i < R));
         check_bit("cl_ready_pre", ready, 1'b0);
      end
      locked_in = 1'b1;
      for (int k = 1; k <= LOCK_TO_READY; k++) begin
         tick();
         check_bit("cl_ready", ready, (k >= LOCK_TO_READY));
         check_bit("cl_dom_rst_n", dom_rst_n, (k >= LOCK_TO_READY));
         check_bit("cl_pll_rst_low", pll_rst, 1'b0);
      end
      check_val("cl_retry", 16'(retry_cnt), 16'd0);
   endtask

   // Driver sequence.
   initial begin
      int j;
      int h;
      int hold;
      logic [3:0] prev_retry;
      logic exp_pr;
      logic exp_f;
      logic [3:0] exp_rc;

      rst_n     = 1'b1;
      locked_in = 1'b0;
      restart   = 1'b0;
      tick();

      // Reset values, then a clean lock with locked_in rising 10 edges after release.
      assert_reset("rst0");
      release_reset();
      clean_lock(10);

      // Lock loss in RUN: outputs drop 3 edges later, then a full re-sequence.
      hold = $urandom_range(1, 5);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_bit("run_hold_ready", ready, 1'b1);
      end
      locked_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_bit("loss_ready", ready, (k < 3));
         check_bit("loss_dom_rst_n", dom_rst_n, (k < 3));
         check_bit("loss_pll_rst", pll_rst, (k >= 3));
      end
      check_val("loss_retry", 16'(retry_cnt), 16'd0);
`ifdef PLL_LOCK_STATS_EN
      check_val("loss_cnt", loss_cnt, 16'd1);
`endif
      h = $urandom_range(5, 20);
      for (int k = 4; k <= h; k++) begin
         tick();
         check_bit("reseq_pll_rst", pll_rst, (k < 3 + R));
         check_bit("reseq_ready", ready, 1'b0);
      end
      locked_in = 1'b1;
      for (int k = 1; k <= LOCK_TO_READY; k++) begin
         tick();
         check_bit("reseq_ready_rise", ready, (k >= LOCK_TO_READY));
      end
      check_val("reseq_retry", 16'(retry_cnt), 16'd0);

      // Async reset in the middle of STABLE.
      assert_reset("rst1");
      release_reset();
      for (int i = 0; i < R + 1; i++) tick();
      locked_in = 1'b1;
      for (int i = 0; i < SYNC_LAT + 1 + 4; i++) tick();
      check_bit("stable_pll_rst", pll_rst, 1'b0);
      check_bit("stable_ready", ready, 1'b0);
      assert_reset("rst_mid_stable");

      // Unstable lock: a 2-cycle drop seen in STABLE restarts qualification.
      release_reset();
      for (int i = 0; i < R + 2; i++) tick();
      locked_in = 1'b1;
      j = $urandom_range(1, 7);
      for (int i = 0; i < j; i++) begin
         tick();
         check_bit("unst_ready_a", ready, 1'b0);
         check_bit("unst_pll_rst_a", pll_rst, 1'b0);
      end
      locked_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_bit("unst_ready_b", ready, 1'b0);
         check_bit("unst_pll_rst_b", pll_rst, 1'b0);
      end
      locked_in = 1'b1;
      for (int k = 1; k <= LOCK_TO_READY; k++) begin
         tick();
         check_bit("unst_ready", ready, (k >= LOCK_TO_READY));
         check_bit("unst_pll_rst", pll_rst, 1'b0);
      end
      check_val("unst_retry", 16'(retry_cnt), 16'd0);

      // Timeout to fault: locked_in stays low through MAX_RETRY attempts.
      assert_reset("rst2");
      exp_q.delete();
      for (int a = 1; a <= M; a++) exp_q.push_back(4'(a));
      prev_retry = 4'd0;
      release_reset();
      for (int i = 1; i <= M * ATTEMPT + 3; i++) begin
         tick();
         if (i >= M * ATTEMPT) begin
            exp_pr = 1'b1;
            exp_rc = 4'(M);
            exp_f  = 1'b1;
         end else begin
            exp_pr = ((i % ATTEMPT) < R);
            exp_rc = 4'(i / ATTEMPT);
            exp_f  = 1'b0;
         end
         check_bit("to_pll_rst", pll_rst, exp_pr);
         check_val("to_retry", 16'(retry_cnt), 16'(exp_rc));
         check_bit("to_fault", fault, exp_f);
         check_bit("to_ready", ready, 1'b0);
         if (retry_cnt !== prev_retry) begin
            if (exp_q.size() > 0) begin
               check_val("to_retry_seq", 16'(retry_cnt), 16'(exp_q.pop_front()));
            end else begin
               check_val("to_retry_extra", 16'(retry_cnt), 16'(prev_retry));
            end
            prev_retry = retry_cnt;
         end
      end
      check_val("to_retry_seq_left", 16'(exp_q.size()), 16'd0);
      hold = $urandom_range(3, 10);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_bit("fault_hold", fault, 1'b1);
         check_bit("fault_pll_rst", pll_rst, 1'b1);
         check_bit("fault_dom_rst_n", dom_rst_n, 1'b0);
      end

      // Restart from FAULT while the synchronized lock is already high.
      locked_in = 1'b1;
      for (int i = 0; i < SYNC_LAT + 1; i++) tick();
      check_bit("pre_restart_fault", fault, 1'b1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check_bit("rs_fault", fault, 1'b0);
      check_val("rs_retry", 16'(retry_cnt), 16'd0);
      check_bit("rs_pll_rst", pll_rst, 1'b1);
      for (int k = 2; k <= R + 2 + S; k++) begin
         tick();
         check_bit("rs_pll_rst_win", pll_rst, (k <= R));
         check_bit("rs_ready", ready, (k >= R + 2 + S));
      end

      // Randomized bring-ups with a random lock arrival inside the wait window.
      for (int n = 0; n < 3; n++) begin
         assert_reset("rst_loop");
         release_reset();
         clean_lock($urandom_range(R, R + 20));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset sequencer and lock supervisor for the video-clock PLL. It holds the PLL in reset after power-up, releases it, and qualifies `locked` over a stability window before releasing the downstream pixel/processing domain reset. It re-sequences the PLL on lock loss or lock timeout and latches a fault after repeated failures. It sits in the refclk (50 MHz) domain, directly beside the PLL wrapper.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock after reset release (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before RUN (≥1).
- `MAX_RETRY`, 3: failed attempts before FAULT (1..15).
- `clk` in 1: 50 MHz reference clock; same net as the PLL refclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked_in` in 1: PLL `locked`; asynchronous to `clk`.
- `restart` in 1: single-cycle pulse; forces a full re-sequence and clears FAULT.
- `pll_rst` out 1: active-high PLL reset.
- `dom_rst_n` out 1: active-low reset for the PLL output-clock domain; the consumer synchronizes it.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retry_cnt` out 4: number of failed attempts since the last RUN or restart.

## Operation
- `locked_in` passes through a 2-flop synchronizer to produce `locked_s`. All decisions use `locked_s`.
- One timer (17 bits minimum; sized from the largest parameter) is cleared on every state entry.
- States and transitions:
  - **PLL_RST**: `pll_rst`=1. Leave for WAIT_LOCK when the timer reaches RST_CYCLES-1.
  - **WAIT_LOCK**: `pll_rst`=0.
    - `locked_s`=1: go to STABLE.
    - Timer reaches LOCK_TIMEOUT-1: `retry_cnt`++. If the new value equals MAX_RETRY, go to FAULT; otherwise go to PLL_RST.
  - **STABLE**:
    - `locked_s`=0: return to WAIT_LOCK with the timer cleared. `retry_cnt` is unchanged.
    - Timer reaches STABLE_CYCLES-1 with `locked_s`=1: go to RUN.
  - **RUN**: `dom_rst_n`=1, `ready`=1, `retry_cnt` cleared on entry.
    - `locked_s`=0: go to PLL_RST. This is a lock loss and does not increment `retry_cnt`.
  - **FAULT**: `pll_rst`=1, `dom_rst_n`=0, `fault`=1. Exit only on `restart`.
- `restart` is honoured in every state. It goes to PLL_RST with `retry_cnt`=0 and the timer cleared, and it overrides any lock or timeout event in the same cycle.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- `dom_rst_n`=0 in every state except RUN.

## Timing
- Reset values (while `rst_n`=0):
  - `pll_rst`=1, `dom_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0.
  - State PLL_RST, timer 0, synchronizer flops 0.
- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_CYCLES rising edges.
- `locked_in` rise to `ready` rise: 2 + STABLE_CYCLES + 1 edges.
- `locked_in` fall in RUN to `ready`/`dom_rst_n` fall: 3 edges. `pll_rst` rises on the same edge.
- `rst_n` asserted mid-operation immediately (asynchronously) forces all reset values, including `pll_rst`=1.
- A `locked_in` glitch shorter than one clock may be missed. A glitch seen in STABLE restarts qualification.

## Configuration
- `PLL_LOCK_STATS_EN` defined:
  - Adds output `loss_cnt` out 16, reset 0.
  - It increments by one on each RUN→PLL_RST lock-loss transition, saturates at 0xFFFF, and is cleared by `restart`.
- Not defined:
  - The port is absent and no counter logic is built.
  - All other behaviour is identical.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2.
- Clean lock: release `rst_n`, raise `locked_in` 10 cycles later and hold it.
  - Required: `pll_rst` high for 4 edges, `ready`/`dom_rst_n` rise 11 edges after `locked_in`, `retry_cnt`=0.
- Unstable lock: raise `locked_in`, drop it for 2 cycles at stable count 5, then hold it.
  - Required: no `ready` until 8 fresh consecutive cycles, `retry_cnt`=0, `pll_rst` never re-asserted.
- Timeout to fault: keep `locked_in`=0.
  - Required: `pll_rst` pulses twice, `retry_cnt` goes 1 then 2, `fault`=1 after the second 32-cycle wait, `pll_rst` held high.
- Lock loss in RUN: drop `locked_in` while `ready`=1.
  - Required: `ready`=0, `dom_rst_n`=0 and `pll_rst`=1 exactly 3 edges later, then a full re-sequence. With the macro defined, `loss_cnt`=1.
- Restart priority: from FAULT, pulse `restart` in the same cycle that `locked_s`=1.
  - Required: PLL_RST next, `fault`=0, `retry_cnt`=0, `pll_rst` high for 4 edges.
- Async reset mid-STABLE: assert `rst_n` between edges.
  - Required: all outputs at reset values immediately, with no dependence on a clock edge.
